// File: rtl/mw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mw_pkg                                                            |
// | Brief  : Shared types and constants for the microwave cook-time controller |
// |          (state encoding, MM:SS BCD time record, quick-start/limit values).|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package mw_pkg;

   // Encoding is fixed because the state port is consumed externally.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_PAUSED = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      RUN    = ST_RUN,
      PAUSED = ST_PAUSED,
      DONE   = ST_DONE
   } state_e;

   localparam int QUICK_START_SEC = 30;
   localparam int MAX_MIN         = 99;
   localparam int MAX_SEC         = 59;

   // MM:SS as four BCD digits; seconds tens is only ever 0-5.
   typedef struct packed {
      logic [3:0] mt;
      logic [3:0] mo;
      logic [2:0] st;
      logic [3:0] so;
   } mw_time_t;

endpackage : mw_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tick_prescaler                                                    |
// | Brief  : Free-running 0..TICKS_PER_SEC-1 counter producing a one-second    |
// |          tick on the cycle the terminal count advances.                    |
// | Ports  : clk, reset (sync, active-low), clear (force 0), hold (freeze),    |
// |          tick (combinational pulse, valid for the current edge)            |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tick_prescaler #(
   parameter int TICKS_PER_SEC = 100
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic hold,
   output logic tick
);

   localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] C_TERM = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (!hold) begin
         cnt_d = (cnt_q == C_TERM) ? '0 : cnt_q + 1'b1;
      end
   end

   // The tick is only real if the count actually advances this edge.
   assign tick = !clear && !hold && (cnt_q == C_TERM);

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/microwave_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : microwave_timer                                                   |
// | Brief  : Microwave cook-time controller. Keypad entry into MM:SS BCD,      |
// |          one-second down-count, start/pause/stop/door handling, heating    |
// |          enable and done flag with timed auto-return to IDLE.              |
// | Ports  : clk, reset (sync, active-low); digit_valid/digit keypad strobe;   |
// |          start/stop strobes; door_open level; min_tens/min_ones/sec_tens/  |
// |          sec_ones BCD time; heating, done, state (registered outputs)      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module microwave_timer
   import mw_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100,
   parameter int DONE_HOLD_SEC = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       start,
   input  logic       stop,
   input  logic       door_open,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [2:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       heating,
   output logic       done,
   output logic [1:0] state
);

   localparam int DW = (DONE_HOLD_SEC > 1) ? $clog2(DONE_HOLD_SEC) : 1;
   localparam logic [DW-1:0] C_DONE_LAST = DW'(DONE_HOLD_SEC - 1);

   // Decrement by one second; only called on a nonzero time.
   function automatic mw_time_t bcd_dec(input mw_time_t t);
      mw_time_t r;
      r = t;
      if (t.so != 4'd0) begin
         r.so = t.so - 4'd1;
      end else begin
         r.so = 4'd9;
         if (t.st != 3'd0) begin
            r.st = t.st - 3'd1;
         end else begin
            r.st = 3'd5;
            if (t.mo != 4'd0) begin
               r.mo = t.mo - 4'd1;
            end else begin
               r.mo = 4'd9;
               r.mt = t.mt - 4'd1;
            end
         end
      end
      return r;
   endfunction

   // Add the quick-start amount (a whole number of tens of seconds) with carry
   // into minutes; a carry out of minutes tens pins the time at the maximum.
   function automatic mw_time_t bcd_add_quick(input mw_time_t t);
      mw_time_t   r;
      logic [3:0] st_sum;
      r      = t;
      st_sum = {1'b0, t.st} + 4'(QUICK_START_SEC / 10);
      if (st_sum >= 4'd6) begin
         r.st = 3'(st_sum - 4'd6);
         if (t.mo != 4'd9) begin
            r.mo = t.mo + 4'd1;
         end else if (t.mt != 4'd9) begin
            r.mo = 4'd0;
            r.mt = t.mt + 4'd1;
         end else begin
            r.mt = 4'(MAX_MIN / 10);
            r.mo = 4'(MAX_MIN % 10);
            r.st = 3'(MAX_SEC / 10);
            r.so = 4'(MAX_SEC % 10);
         end
      end else begin
         r.st = st_sum[2:0];
      end
      return r;
   endfunction

   state_e          state_q,    state_d;
   mw_time_t        time_q,     time_d;
   logic [DW-1:0]   done_sec_q, done_sec_d;
   logic            heating_q;
   logic            done_q;

   logic            w_tick;
   logic            w_pre_clear;
   logic            w_pre_hold;
   mw_time_t        w_time_dec;

   // Prescaler sits at zero through IDLE so every start begins a full second.
   assign w_pre_clear = (state_q == IDLE);
   assign w_pre_hold  = (state_q == PAUSED) ||
                        ((state_q == RUN) && (stop || door_open));

   tick_prescaler #(
      .TICKS_PER_SEC (TICKS_PER_SEC)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear (w_pre_clear),
      .hold  (w_pre_hold),
      .tick  (w_tick)
   );

   assign w_time_dec = bcd_dec(time_q);

   always_comb begin
      state_d    = state_q;
      time_d     = time_q;
      done_sec_d = '0;
      case (state_q)
         IDLE: begin
            if (stop) begin
               time_d = '0;
            end else if (start) begin
               // A start strobe consumes the edge even if the door blocks it.
               if (!door_open) begin
                  if (time_q == '0) begin
                     time_d = bcd_add_quick(time_q);
                  end
                  state_d = RUN;
               end
            end else if (digit_valid && (digit <= 4'd9) &&
                         (time_q.mt == 4'd0) && (time_q.so <= 4'd5)) begin
               time_d.mt = time_q.mo;
               time_d.mo = {1'b0, time_q.st};
               time_d.st = time_q.so[2:0];
               time_d.so = digit;
            end
         end
         RUN: begin
            if (stop || door_open) begin
               state_d = PAUSED;
            end else if (start) begin
               time_d = bcd_add_quick(time_q);
            end else if (w_tick) begin
               time_d = w_time_dec;
               if (w_time_dec == '0) begin
                  state_d = DONE;
               end
            end
         end
         PAUSED: begin
            if (stop) begin
               state_d = IDLE;
               time_d  = '0;
            end else if (start && !door_open) begin
               state_d = RUN;
            end
         end
         DONE: begin
            done_sec_d = done_sec_q;
            time_d     = '0;
            if (stop || door_open) begin
               state_d    = IDLE;
               done_sec_d = '0;
            end else if (w_tick) begin
               if (done_sec_q == C_DONE_LAST) begin
                  state_d    = IDLE;
                  done_sec_d = '0;
               end else begin
                  done_sec_d = done_sec_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            time_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         time_q     <= '0;
         done_sec_q <= '0;
         heating_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         time_q     <= time_d;
         done_sec_q <= done_sec_d;
         heating_q  <= (state_d == RUN);
         done_q     <= (state_d == DONE);
      end
   end

   assign min_tens = time_q.mt;
   assign min_ones = time_q.mo;
   assign sec_tens = time_q.st;
   assign sec_ones = time_q.so;
   assign heating  = heating_q;
   assign done     = done_q;
   assign state    = state_q;

endmodule : microwave_timer
`default_nettype wire

// File: tb/tb_microwave_timer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module : tb_microwave_timer                                                |
// | Brief  : Self-checking bench for microwave_timer: directed scenarios plus  |
// |          randomized keypad/start/stop/door/reset traffic compared every    |
// |          cycle against a seconds-based reference model.                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_microwave_timer;

   localparam int T = 4;
   localparam int H = 3;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       digit_valid = 1'b0;
   logic [3:0] digit = 4'd0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       door_open = 1'b0;
   logic [3:0] min_tens, min_ones, sec_ones;
   logic [2:0] sec_tens;
   logic       heating, done;
   logic [1:0] state;

   microwave_timer #(
      .TICKS_PER_SEC (T),
      .DONE_HOLD_SEC (H)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .digit_valid (digit_valid),
      .digit       (digit),
      .start       (start),
      .stop        (stop),
      .door_open   (door_open),
      .min_tens    (min_tens),
      .min_ones    (min_ones),
      .sec_tens    (sec_tens),
      .sec_ones    (sec_ones),
      .heating     (heating),
      .done        (done),
      .state       (state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: whole minutes/seconds, prescaler count, DONE seconds.
   int m_min = 0, m_sec = 0, m_st = M_IDLE, m_pc = 0, m_dc = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input bit rst_n, input bit dv, input int dg,
                             input bit st, input bit sp, input bit door);
      bit tk;
      int tot;
      if (!rst_n) begin
         m_min = 0; m_sec = 0; m_st = M_IDLE; m_pc = 0; m_dc = 0;
         return;
      end
      case (m_st)
         M_IDLE: begin
            if (sp) begin
               m_min = 0; m_sec = 0;
            end else if (st) begin
               if (!door) begin
                  if (m_min == 0 && m_sec == 0) m_sec = 30;
                  m_st = M_RUN;
               end
            end else if (dv && dg <= 9 && m_min < 10 && (m_sec % 10) <= 5) begin
               m_min = (m_min % 10) * 10 + m_sec / 10;
               m_sec = (m_sec % 10) * 10 + dg;
            end
            m_pc = 0;
         end
         M_RUN: begin
            if (sp || door) begin
               m_st = M_PAUSED;
            end else begin
               tk   = (m_pc == T - 1);
               m_pc = (m_pc + 1) % T;
               tot  = m_min * 60 + m_sec;
               if (st) begin
                  tot = tot + 30;
                  if (tot > 99 * 60 + 59) tot = 99 * 60 + 59;
               end else if (tk) begin
                  tot = tot - 1;
                  if (tot == 0) begin
                     m_st = M_DONE;
                     m_dc = 0;
                  end
               end
               m_min = tot / 60;
               m_sec = tot % 60;
            end
         end
         M_PAUSED: begin
            if (sp) begin
               m_st = M_IDLE; m_min = 0; m_sec = 0;
            end else if (st && !door) begin
               m_st = M_RUN;
            end
         end
         default: begin
            tk   = (m_pc == T - 1);
            m_pc = (m_pc + 1) % T;
            if (sp || door) begin
               m_st = M_IDLE; m_dc = 0;
            end else if (tk) begin
               m_dc++;
               if (m_dc == H) begin
                  m_st = M_IDLE; m_dc = 0;
               end
            end
         end
      endcase
   endtask

   function automatic logic [19:0] exp_obs();
      return {4'(m_min / 10), 4'(m_min % 10), 1'b0, 3'(m_sec / 10), 4'(m_sec % 10),
              (m_st == M_RUN), (m_st == M_DONE), 2'(m_st)};
   endfunction

   function automatic logic [19:0] dut_obs();
      return {min_tens, min_ones, 1'b0, sec_tens, sec_ones, heating, done, state};
   endfunction

   function automatic logic [15:0] disp();
      return {min_tens, min_ones, 1'b0, sec_tens, sec_ones};
   endfunction

   // One clock: drive, update the model on the edge, compare just after it.
   task automatic cyc(input bit rst_n, input bit dv, input logic [3:0] dg,
                      input bit st, input bit sp, input bit door);
      reset       = rst_n;
      digit_valid = dv;
      digit       = dg;
      start       = st;
      stop        = sp;
      door_open   = door;
      @(posedge clk);
      model_edge(rst_n, dv, int'(dg), st, sp, door);
      #1;
      check_eq("cycle", 32'(dut_obs()), 32'(exp_obs()));
      digit_valid = 1'b0;
      start       = 1'b0;
      stop        = 1'b0;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 4'd0, 0, 0, 0);
   endtask

   task automatic key(input logic [3:0] d);
      cyc(1, 1, d, 0, 0, 0);
   endtask

   task automatic press_start();
      cyc(1, 0, 4'd0, 1, 0, 0);
   endtask

   task automatic press_stop();
      cyc(1, 0, 4'd0, 0, 1, 0);
   endtask

   initial begin
      bit door_lvl;

      // Reset state
      cyc(0, 0, 4'd0, 0, 0, 0);
      cyc(0, 0, 4'd0, 0, 0, 0);
      check_eq("reset_state", 32'(dut_obs()), 32'h0);

      // 1: entry and borrow through seconds tens into minutes
      key(4'd1); key(4'd0); key(4'd5);
      check_eq("entry_0105", 32'(disp()), 32'h0105);
      press_start();
      check_eq("run_heating", 32'(heating), 32'h1);
      idle_n(24);
      check_eq("borrow_0059", 32'(disp()), 32'h0059);
      check_eq("still_heating", 32'(heating), 32'h1);
      press_stop(); press_stop();

      // 2: completion and auto-return
      key(4'd2);
      press_start();
      idle_n(8);
      check_eq("done_state", 32'({state, done, heating}), 32'({2'd3, 1'b1, 1'b0}));
      idle_n(12);
      check_eq("done_return", 32'({state, done}), 32'({2'd0, 1'b0}));

      // 3: door pause freezes digits and prescaler
      key(4'd1); key(4'd5);
      press_start();
      idle_n(22);
      check_eq("pre_door_0010", 32'(disp()), 32'h0010);
      for (int i = 0; i < 20; i++) cyc(1, 0, 4'd0, 0, 0, 1);
      check_eq("door_frozen", 32'({disp(), state}), 32'({16'h0010, 2'd2}));
      press_start();
      idle_n(1);
      check_eq("resume_no_dec", 32'(disp()), 32'h0010);
      idle_n(1);
      check_eq("resume_dec", 32'(disp()), 32'h0009);
      press_stop(); press_stop();

      // 4: quick start, +30, saturation
      press_start();
      check_eq("quick_0030", 32'({disp(), state}), 32'({16'h0030, 2'd1}));
      press_start();
      check_eq("add_0100", 32'(disp()), 32'h0100);
      press_stop(); press_stop();
      key(4'd5); key(4'd5); key(4'd1); key(4'd0);
      press_start();
      for (int i = 0; i < 89; i++) press_start();
      check_eq("reach_9940", 32'(disp()), 32'h9940);
      press_start();
      check_eq("sat_9959", 32'(disp()), 32'h9959);
      press_start();
      check_eq("sat_hold", 32'(disp()), 32'h9959);
      press_stop(); press_stop();

      // 5: entry rules and same-edge priority
      key(4'd7); key(4'd1);
      check_eq("entry_0007", 32'(disp()), 32'h0007);
      press_stop();
      key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
      check_eq("entry_full", 32'(disp()), 32'h1234);
      press_start();
      cyc(1, 0, 4'd0, 1, 1, 0);
      check_eq("stop_beats_start", 32'({disp(), state}), 32'({16'h1234, 2'd2}));

      // 6: reset mid-run
      press_start();
      idle_n(3);
      cyc(0, 0, 4'd0, 0, 0, 0);
      check_eq("reset_midrun", 32'(dut_obs()), 32'h0);

      // Randomized traffic against the model
      door_lvl = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         bit r_n, dv, st, sp;
         logic [3:0] dg;
         if ($urandom_range(0, 49) == 0) door_lvl = ~door_lvl;
         r_n = ($urandom_range(0, 599) != 0);
         dv  = ($urandom_range(0, 3) == 0);
         dg  = 4'($urandom_range(0, 11));
         st  = ($urandom_range(0, 39) == 0);
         sp  = ($urandom_range(0, 69) == 0);
         cyc(r_n, dv, dg, st, sp, door_lvl);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_microwave_timer
`default_nettype wire
